// File: rtl/mi_tmp_comp_c.sv
// mi_tmp_comp_c -- serial-lane test compressor.
//
// Each serial input lane fills a CFrame-bit shift register. The lanes together
// form the parallel word AParO, and every CFrame enabled cycles a frame is
// committed and AFrameO pulses. In the other direction, the wide capture bus
// ACapI is split into one slice per lane. Each slice is XOR-folded into a
// per-lane MISR, and the MISR MSBs drive the serial output lanes. The MISRs
// stay at CSeed until the first frame commit (FLUSH) and then run (RUN).
//
// Optional feature (macro MI_TMP_COMP_SHADOW_EN):
//   defined   : AParO is a shadow register, loaded only at frame commit.
//   undefined : AParO follows the shift registers live.
//
// Ports:
//   AClkH    in   1       clock, rising edge
//   AResetH  in   1       asynchronous active-high reset
//   AClkHEn  in   1       clock enable; all state advances only when high
//   ADataI   in   CLanes  serial input lanes
//   ADataO   out  CLanes  serial output lanes (MISR MSBs, 0 during FLUSH)
//   ACapI    in   CLenI   bus to be compressed
//   AParO    out  CLenO   parallel word assembled from the serial inputs
//   AFrameO  out  1       one-clock pulse after each frame commit
//
// The design assumes CFrame = ceil(CLenO/CLanes) is at least 2.
module mi_tmp_comp_c #(
  parameter int                 CLenI  = 256,
  parameter int                 CLenO  = 128,
  parameter int                 CLanes = 2,
  parameter int                 CMisrW = 32,
  parameter logic [CMisrW-1:0]  CPoly  = CMisrW'(32'h04C11DB7),
  parameter logic [CMisrW-1:0]  CSeed  = '0
) (
  input  logic              AClkH,
  input  logic              AResetH,
  input  logic              AClkHEn,
  input  logic [CLanes-1:0] ADataI,
  output logic [CLanes-1:0] ADataO,
  input  logic [CLenI-1:0]  ACapI,
  output logic [CLenO-1:0]  AParO,
  output logic              AFrameO
);

  localparam int CFrame  = (CLenO + CLanes - 1) / CLanes;
  localparam int CSliceW = (CLenI + CLanes - 1) / CLanes;
  localparam int NChunk  = (CSliceW + CMisrW - 1) / CMisrW;
  localparam int FcW     = (CFrame > 1) ? $clog2(CFrame) : 1;
  localparam logic [FcW-1:0] FcLast = FcW'(CFrame - 1);

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [FcW-1:0]            fc;
  logic                      last;
  logic                      commit;
  logic                      frame_p1;
  logic [CFrame-1:0]         sr      [CLanes];
  logic [CFrame-1:0]         sr_nxt  [CLanes];
  logic [CMisrW-1:0]         misr    [CLanes];
  logic [CMisrW-1:0]         fold_p0 [CLanes];
  logic [CLanes*CSliceW-1:0] cap_ext;

  // XOR-fold one zero-padded lane slice down to MISR width.
  function automatic logic [CMisrW-1:0] fold(input logic [CSliceW-1:0] s);
    logic [NChunk*CMisrW-1:0] pad;
    logic [CMisrW-1:0]        acc;
    pad              = '0;
    pad[CSliceW-1:0] = s;
    acc              = '0;
    for (int i = 0; i < NChunk; i++) begin
      acc = acc ^ pad[i*CMisrW +: CMisrW];
    end
    return acc;
  endfunction

  // One Galois-style MISR step: shift left, reduce by CPoly, absorb input.
  function automatic logic [CMisrW-1:0] misr_step(input logic [CMisrW-1:0] m,
                                                  input logic [CMisrW-1:0] f);
    logic [CMisrW-1:0] sh;
    sh = {m[CMisrW-2:0], 1'b0};
    if (m[CMisrW-1]) begin
      sh = sh ^ CPoly;
    end
    return sh ^ f;
  endfunction

  assign last    = (fc == FcLast);
  assign commit  = AClkHEn && last;
  assign cap_ext = (CLanes*CSliceW)'(ACapI);
  assign AFrameO = frame_p1;

  // Stage p0: per-lane next shift value, folded capture slice, serial output.
  // ADataO comes only from registered state, so ACapI has no path to it.
  always_comb begin
    ADataO = '0;
    for (int l = 0; l < CLanes; l++) begin
      sr_nxt[l]  = {sr[l][CFrame-2:0], ADataI[l]};
      fold_p0[l] = fold(cap_ext[l*CSliceW +: CSliceW]);
      ADataO[l]  = (state == RUN) && misr[l][CMisrW-1];
    end
  end

  always_comb begin
    state_nxt = state;
    if (commit) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      state <= FLUSH;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p1: shift registers, frame counter, MISRs and the commit pulse.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      fc       <= '0;
      frame_p1 <= 1'b0;
      for (int l = 0; l < CLanes; l++) begin
        sr[l]   <= '0;
        misr[l] <= CSeed;
      end
    end else begin
      frame_p1 <= commit;
      if (AClkHEn) begin
        fc <= last ? '0 : fc + FcW'(1);
        for (int l = 0; l < CLanes; l++) begin
          sr[l]   <= sr_nxt[l];
          misr[l] <= (state == RUN) ? misr_step(misr[l], fold_p0[l]) : CSeed;
        end
      end
    end
  end

`ifdef MI_TMP_COMP_SHADOW_EN
  logic [CLanes*CFrame-1:0] par_nxt;
  logic [CLenO-1:0]         shadow;

  // The shadow takes the post-shift word so the commit cycle's bit is included.
  always_comb begin
    par_nxt = '0;
    for (int l = 0; l < CLanes; l++) begin
      par_nxt[l*CFrame +: CFrame] = sr_nxt[l];
    end
  end

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      shadow <= '0;
    end else if (commit) begin
      shadow <= par_nxt[CLenO-1:0];
    end
  end

  assign AParO = shadow;
`else
  logic [CLanes*CFrame-1:0] par_live;

  always_comb begin
    par_live = '0;
    for (int l = 0; l < CLanes; l++) begin
      par_live[l*CFrame +: CFrame] = sr[l];
    end
  end

  assign AParO = par_live[CLenO-1:0];
`endif

endmodule
